// File: rtl/demux_shift_unit.sv
// Steered-destination serial shift unit: loads or shifts one of two registers (A/B)
// selected by a 1-to-2 demux, sequenced by a three-state IDLE/SHIFT/HOLD controller.
module demux_shift_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Select,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             Execute,
  input  logic             Sin,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Sout,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] reg_a, reg_a_next;
  logic [WIDTH-1:0] reg_b, reg_b_next;
  logic             sel_q, sel_q_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      reg_a <= '0;
      reg_b <= '0;
      sel_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      reg_a <= reg_a_next;
      reg_b <= reg_b_next;
      sel_q <= sel_q_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    reg_a_next = reg_a;
    reg_b_next = reg_b;
    sel_q_next = sel_q;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        // Load and Execute may coincide: the load lands now, shifting starts next cycle.
        if (Load) begin
          if (Select) reg_a_next = Din;
          else        reg_b_next = Din;
        end
        if (Execute) begin
          sel_q_next = Select;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sel_q) reg_a_next = {Sin, reg_a[WIDTH-1:1]};
        else       reg_b_next = {Sin, reg_b[WIDTH-1:1]};
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!Execute) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outside IDLE the destination is the latched one, so Select changes cannot disturb Sout.
  always_comb begin
    Sout = 1'b0;
    if (state == IDLE) Sout = Select ? reg_a[0] : reg_b[0];
    else               Sout = sel_q  ? reg_a[0] : reg_b[0];
  end

  assign A    = reg_a;
  assign B    = reg_b;
  assign Busy = (state == SHIFT);
  assign Done = (state == HOLD);

endmodule

// File: tb/tb_demux_shift_unit.sv
// Randomized and directed bench for demux_shift_unit against a run-count reference model.
module tb_demux_shift_unit;

  localparam int unsigned WIDTH = 8;

  logic             Clk = 1'b0;
  logic             Reset, Select, Load, Execute, Sin;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] A, B;
  logic             Sout, Busy, Done;

  demux_shift_unit #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Select(Select), .Load(Load), .Din(Din),
    .Execute(Execute), .Sin(Sin), .A(A), .B(B), .Sout(Sout), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining shift count plus a "finished, awaiting release" flag.
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic             m_sel = 1'b0;
  int               m_left = 0;
  bit               m_fin = 1'b0;

  logic last_sout;
  int   busy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic sel, input logic ld,
                       input logic [WIDTH-1:0] din, input logic exe, input logic sin);
    logic exp_sout;
    logic running;
    @(negedge Clk);
    Reset = rst; Select = sel; Load = ld; Din = din; Execute = exe; Sin = sin;
    #1;
    running  = (m_left > 0) || m_fin;
    exp_sout = running ? (m_sel ? m_a[0] : m_b[0]) : (sel ? m_a[0] : m_b[0]);
    check("A", 32'(A), 32'(m_a));
    check("B", 32'(B), 32'(m_b));
    check("busy", 32'(Busy), 32'(m_left > 0));
    check("done", 32'(Done), 32'(m_fin));
    check("sout", 32'(Sout), 32'(exp_sout));
    last_sout = Sout;
    if (Busy) busy_seen++;
    @(posedge Clk);
    if (rst) begin
      m_a = '0; m_b = '0; m_sel = 1'b0; m_left = 0; m_fin = 1'b0;
    end else if (m_left > 0) begin
      if (m_sel) m_a = (m_a >> 1) | (WIDTH'(sin) << (WIDTH - 1));
      else       m_b = (m_b >> 1) | (WIDTH'(sin) << (WIDTH - 1));
      m_left--;
      if (m_left == 0) m_fin = 1'b1;
    end else if (m_fin) begin
      if (!exe) m_fin = 1'b0;
    end else begin
      if (ld) begin
        if (sel) m_a = din;
        else     m_b = din;
      end
      if (exe) begin
        m_sel  = sel;
        m_left = WIDTH;
      end
    end
  endtask

  logic [WIDTH-1:0] pat;

  initial begin
    Reset = 1'b1; Select = 1'b0; Load = 1'b0; Din = '0; Execute = 1'b0; Sin = 1'b0;

    // Reset and parallel loads
    cycle(1, 0, 0, 8'h00, 0, 0);
    cycle(1, 0, 0, 8'h00, 0, 0);
    #2 check("rst_A", 32'(A), 32'h00);
    check("rst_busy", 32'(Busy), 0);
    cycle(0, 1, 1, 8'h5A, 0, 0);
    #2 check("load_A", 32'(A), 32'h5A);
    cycle(0, 0, 1, 8'hC3, 0, 0);
    #2 check("load_B", 32'(B), 32'hC3);
    check("load_A_kept", 32'(A), 32'h5A);

    // Run on A with Sin=1, single-cycle Execute pulse
    busy_seen = 0;
    pat = 8'h5A;
    cycle(0, 1, 0, 8'h00, 1, 1);
    for (int unsigned k = 0; k < WIDTH; k++) begin
      cycle(0, 1, 0, 8'h00, 0, 1);
      check("run1_sout", 32'(last_sout), 32'(pat[k]));
    end
    #2 check("run1_A", 32'(A), 32'hFF);
    check("run1_B", 32'(B), 32'hC3);
    check("run1_busy_cnt", 32'(busy_seen), WIDTH);
    check("run1_done", 32'(Done), 1);
    cycle(0, 1, 0, 8'h00, 0, 0);
    #2 check("run1_idle", 32'(Done | Busy), 0);

    // Run on B, Select/Load toggled mid-run must be ignored
    cycle(0, 0, 1, 8'hFF, 0, 0);
    cycle(0, 0, 0, 8'h00, 1, 0);
    for (int unsigned k = 0; k < WIDTH; k++)
      cycle(0, k[0], 1, 8'h00, 0, (k == 0) ? 1'b1 : 1'b0);
    #2 check("run2_B", 32'(B), 32'h01);
    check("run2_A", 32'(A), 32'hFF);
    cycle(0, 0, 0, 8'h00, 0, 0);

    // Execute held for 30 cycles yields one run
    busy_seen = 0;
    for (int i = 0; i < 30; i++) cycle(0, 1, 0, 8'h00, 1, $urandom_range(0, 1));
    check("held_busy_cnt", 32'(busy_seen), WIDTH);
    #2 check("held_done", 32'(Done), 1);
    cycle(0, 1, 0, 8'h00, 0, 0);
    #2 check("held_idle", 32'(Done | Busy), 0);

    // Reset on the 4th shift cycle
    cycle(0, 1, 0, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h00, 0, 1);
    cycle(1, 1, 0, 8'h00, 0, 1);
    #2 check("midrst_A", 32'(A), 0);
    check("midrst_B", 32'(B), 0);
    check("midrst_flags", 32'({Busy, Done}), 0);
    cycle(0, 1, 1, 8'h81, 0, 0);
    #2 check("postrst_load", 32'(A), 32'h81);

    // Load and Execute in the same IDLE cycle
    cycle(0, 1, 1, 8'h0F, 1, 0);
    #2 check("ldex_A", 32'(A), 32'h0F);
    pat = 8'h0F;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      cycle(0, 1, 0, 8'h00, 0, 0);
      check("ldex_sout", 32'(last_sout), 32'(pat[k]));
    end
    #2 check("ldex_A_end", 32'(A), 32'h00);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 99) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
            8'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
